csr_access_ctrl: RTL and testbench

//  Sequences all CSR accesses for the core: accepts CSRRW/CSRRS/CSRRC requests

---
 rtl/csr_access_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences CSRRW/CSRRS/CSRRC accesses from EX against trap
// entry and MRET. It holds the machine CSRs and the 64-bit cycle/instret
// counters. Every request goes through IDLE -> ACCESS -> RESP, and a response
// follows two cycles after acceptance.
//
// Optional feature: define CSR_HI_SNAPSHOT_EN to make a read of a counter's
// low word latch that counter's high word into a shadow register. Reads of
// 0xC80/0xC82 then return the shadow, which gives a tear-free lo-then-hi
// sequence. Without the macro, the high-word reads return live bits.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready; trap/mret are taken here, otherwise a request is accepted
// S_ACCESS| read-modify-write of the captured CSR, result registered
// S_RESP  | rsp_valid pulse with the registered old value / error
module csr_access_ctrl #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      CNT_W     = 64,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  output logic            trap_ready,
  input  logic            mret_valid,
  input  logic            retire,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [11:0]      addr_q;
  logic [XLEN-1:0]  wdata_q, rdata_q;
  logic             err_q;
  logic             mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0]  mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0]  mepc_q, mepc_d, mcause_q, mcause_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             trap_take, mret_take, req_take;
  logic [XLEN-1:0]  old_val, new_val;
  logic             mapped, read_only, wr_intent, acc_err, acc_we;

`ifdef CSR_HI_SNAPSHOT_EN
  logic [XLEN-1:0]  cycle_hi_sh_q, instret_hi_sh_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshakes. In IDLE the priority is trap > mret > request.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    trap_ready = 1'b0;
    trap_take  = 1'b0;
    mret_take  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trap_valid) begin
          trap_ready = 1'b1;
          trap_take  = 1'b1;
        end else if (mret_valid) begin
          mret_take = 1'b1;
        end else begin
          req_ready = 1'b1;
          if (req_valid) state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (rst) begin
      state_d    = S_IDLE;
      req_ready  = 1'b0;
      trap_ready = 1'b0;
      trap_take  = 1'b0;
      mret_take  = 1'b0;
    end
  end

  assign req_take = req_ready & req_valid;

  // Address decode, old-value read and modify for the captured request.
  always_comb begin
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (addr_q)
      12'h300: begin
        old_val[3] = mie_q;
        old_val[7] = mpie_q;
      end
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'hC00: begin
        old_val   = cycle_q[XLEN-1:0];
        read_only = 1'b1;
      end
      12'hC02: begin
        old_val   = instret_q[XLEN-1:0];
        read_only = 1'b1;
      end
      12'hC80: begin
`ifdef CSR_HI_SNAPSHOT_EN
        old_val   = cycle_hi_sh_q;
`else
        old_val   = cycle_q[CNT_W-1:XLEN];
`endif
        read_only = 1'b1;
      end
      12'hC82: begin
`ifdef CSR_HI_SNAPSHOT_EN
        old_val   = instret_hi_sh_q;
`else
        old_val   = instret_q[CNT_W-1:XLEN];
`endif
        read_only = 1'b1;
      end
      default: mapped = 1'b0;
    endcase
    new_val = wdata_q;
    case (op_q)
      OP_RS:   new_val = old_val | wdata_q;
      OP_RC:   new_val = old_val & ~wdata_q;
      default: new_val = wdata_q;
    endcase
    // Set/clear with a zero operand is a pure read, so it is legal on RO CSRs.
    wr_intent = (op_q == OP_RW) || (wdata_q != '0);
    acc_err   = !mapped || (op_q == 2'b00) || (read_only && wr_intent);
    acc_we    = (state_q == S_ACCESS) && !acc_err && wr_intent;
  end

  // Architectural CSR next state: trap/mret updates, then CSR writes.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_take) begin
      mepc_d   = trap_pc & ~XLEN'(1);
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_take) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
    if (acc_we) begin
      case (addr_q)
        12'h300: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        12'h305: mtvec_d    = new_val & ~XLEN'(3);
        12'h340: mscratch_d = new_val;
        12'h341: mepc_d     = new_val & ~XLEN'(1);
        12'h342: mcause_d   = new_val;
        default: ;
      endcase
    end
  end

  // Request capture, response registers, CSRs and free-running counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      if (req_take) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_ACCESS) begin
        rdata_q <= acc_err ? '0 : old_val;
        err_q   <= acc_err;
      end
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      cycle_q    <= cycle_q + CNT_W'(1);
      instret_q  <= instret_q + CNT_W'(retire);
    end
  end

`ifdef CSR_HI_SNAPSHOT_EN
  // A successful low-word read latches the high word that belongs with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_hi_sh_q   <= '0;
      instret_hi_sh_q <= '0;
    end else if ((state_q == S_ACCESS) && !acc_err) begin
      if (addr_q == 12'hC00) cycle_hi_sh_q   <= cycle_q[CNT_W-1:XLEN];
      if (addr_q == 12'hC02) instret_hi_sh_q <= instret_q[CNT_W-1:XLEN];
    end
  end
`endif

  assign rsp_valid = (state_q == S_RESP) && !rst;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;
  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;
  assign mie_o     = mie_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Testbench for csr_access_ctrl. A time-indexed reference model is checked
// against the DUT on every cycle. Directed sequences pin literal results, and
// a randomized phase follows them.
`timescale 1ns/1ps
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = 12'h000;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_cause = 32'h0;
  logic        trap_ready;
  logic        mret_valid = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] mtvec_o, mepc_o;
  logic        mie_o;

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_ready(trap_ready), .mret_valid(mret_valid), .retire(retire),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model state: architectural CSRs plus one pending request tagged
  // with its acceptance cycle. It is accessed at +1 and answered at +2.
  int unsigned t = 0;
  bit          m_mie, m_mpie;
  bit [31:0]   m_mtvec, m_mscratch, m_mepc, m_mcause, m_shc, m_shi;
  bit [63:0]   m_cyc, m_ins;
  bit          pend_v;
  int unsigned pend_t;
  bit [1:0]    pend_op;
  bit [11:0]   pend_addr;
  bit [31:0]   pend_wdata, pend_rdata;
  bit          pend_err;

  always @(negedge clk) begin : model_check
    bit idle, e_tr, e_rr, e_rv, mret_eff, mapped, ro, wr, err;
    bit [31:0] old, nv;
    t++;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_trap_ready", trap_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_shc = 0; m_shi = 0; m_cyc = 0; m_ins = 0; pend_v = 0;
    end else begin
      idle     = !pend_v;
      e_tr     = idle && trap_valid;
      e_rr     = idle && !trap_valid && !mret_valid;
      mret_eff = idle && !trap_valid && mret_valid;
      e_rv     = pend_v && (t == pend_t + 2);
      chk("req_ready", req_ready, e_rr);
      chk("trap_ready", trap_ready, e_tr);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_rdata", rsp_rdata, e_rv ? pend_rdata : 32'h0);
      chk("rsp_err", rsp_err, e_rv ? pend_err : 1'b0);
      chk("mtvec_o", mtvec_o, m_mtvec);
      chk("mepc_o", mepc_o, m_mepc);
      chk("mie_o", mie_o, m_mie);

      if (pend_v && (t == pend_t + 1)) begin
        mapped = 1; ro = 0; old = 0;
        case (pend_addr)
          12'h300: old = {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
          12'h305: old = m_mtvec;
          12'h340: old = m_mscratch;
          12'h341: old = m_mepc;
          12'h342: old = m_mcause;
          12'hC00: begin old = m_cyc[31:0]; ro = 1; end
          12'hC02: begin old = m_ins[31:0]; ro = 1; end
`ifdef CSR_HI_SNAPSHOT_EN
          12'hC80: begin old = m_shc; ro = 1; end
          12'hC82: begin old = m_shi; ro = 1; end
`else
          12'hC80: begin old = m_cyc[63:32]; ro = 1; end
          12'hC82: begin old = m_ins[63:32]; ro = 1; end
`endif
          default: mapped = 0;
        endcase
        wr  = (pend_op == 2'b01) || (pend_wdata != 0);
        err = !mapped || (pend_op == 2'b00) || (ro && wr);
        nv  = (pend_op == 2'b01) ? pend_wdata :
              (pend_op == 2'b10) ? (old | pend_wdata) : (old & ~pend_wdata);
        pend_rdata = err ? 32'h0 : old;
        pend_err   = err;
        if (!err && wr) begin
          case (pend_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec = {nv[31:2], 2'b00};
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = {nv[31:1], 1'b0};
            12'h342: m_mcause = nv;
            default: ;
          endcase
        end
`ifdef CSR_HI_SNAPSHOT_EN
        if (!err && pend_addr == 12'hC00) m_shc = m_cyc[63:32];
        if (!err && pend_addr == 12'hC02) m_shi = m_ins[63:32];
`endif
      end
      if (e_rv) pend_v = 0;
      if (e_tr) begin
        m_mepc = {trap_pc[31:1], 1'b0};
        m_mcause = trap_cause;
        m_mpie = m_mie;
        m_mie = 0;
      end else if (mret_eff) begin
        m_mie = m_mpie;
        m_mpie = 1;
      end
      if (e_rr && req_valid) begin
        pend_v = 1; pend_t = t; pend_op = req_op; pend_addr = req_addr; pend_wdata = req_wdata;
      end
      m_cyc = m_cyc + 1;
      if (retire) m_ins = m_ins + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Issue one request from IDLE and return its response and latency.
  task automatic do_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    int n;
    bit acc;
    req_valid = 1; req_op = op; req_addr = a; req_wdata = d;
    acc = 0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = req_ready;
      n++;
      tick();
    end
    req_valid = 0;
    if (!acc) chk("req_accept_timeout", 0, 1);
    lat = 0; rd = 32'h0; e = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; e = rsp_err;
        break;
      end
      tick();
    end
    tick();
  endtask

  logic [11:0] addrs [12] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hC00,
                              12'hC80, 12'hC02, 12'hC82, 12'h301, 12'hC01, 12'h7FF};

  initial begin : stim
    logic [31:0] rd;
    logic e;
    int lat;

    // 1: reset, then a zero-operand set on mtvec
    repeat (3) tick();
    rst = 0;
    chk("t1_mtvec_rst", mtvec_o, 32'h0);
    chk("t1_mepc_rst", mepc_o, 32'h0);
    chk("t1_mie_rst", mie_o, 0);
    do_req(2'b10, 12'h305, 32'h0, rd, e, lat);
    chk("t1_lat", lat, 2);
    chk("t1_rdata", rd, 32'h0);
    chk("t1_err", e, 0);

    // 2: mscratch read-modify-write
    do_req(2'b01, 12'h340, 32'hA5A5_A5A5, rd, e, lat);
    chk("t2_rw_old", rd, 32'h0);
    do_req(2'b11, 12'h340, 32'h0000_00FF, rd, e, lat);
    chk("t2_rc_old", rd, 32'hA5A5_A5A5);
    do_req(2'b01, 12'h340, 32'h0, rd, e, lat);
    chk("t2_rw_old2", rd, 32'hA5A5_A500);

    // 3: write to RO counter is an error; a zero-operand set is a legal read
    do_req(2'b01, 12'hC00, 32'h1, rd, e, lat);
    chk("t3_ro_err", e, 1);
    chk("t3_ro_rdata", rd, 32'h0);
    do_req(2'b10, 12'hC00, 32'h0, rd, e, lat);
    chk("t3_read_err", e, 0);
    chk("t3_cycle_nonzero", rd != 0, 1);

    // 4: trap wins over a simultaneous request, then mret
    do_req(2'b10, 12'h300, 32'h8, rd, e, lat);
    chk("t4_mstatus_old", rd, 32'h0);
    chk("t4_mie_set", mie_o, 1);
    trap_valid = 1; trap_pc = 32'h103; trap_cause = 32'hB;
    req_valid = 1; req_op = 2'b10; req_addr = 12'h342; req_wdata = 32'h0;
    @(negedge clk);
    chk("t4_trap_ready", trap_ready, 1);
    chk("t4_req_blocked", req_ready, 0);
    tick();
    trap_valid = 0;
    do_req(2'b10, 12'h342, 32'h0, rd, e, lat);
    chk("t4_mcause", rd, 32'hB);
    chk("t4_req_lat", lat, 2);
    chk("t4_mepc", mepc_o, 32'h102);
    chk("t4_mie_cleared", mie_o, 0);
    do_req(2'b10, 12'h300, 32'h0, rd, e, lat);
    chk("t4_mstatus_trap", rd, 32'h80);
    mret_valid = 1;
    @(negedge clk);
    chk("t4_mret_req_ready", req_ready, 0);
    tick();
    mret_valid = 0;
    @(negedge clk);
    chk("t4_mret_mie", mie_o, 1);
    tick();
    do_req(2'b10, 12'h300, 32'h0, rd, e, lat);
    chk("t4_mstatus_mret", rd, 32'h88);

    // 5: cycle counter about to carry into the high word
    req_valid = 1; req_op = 2'b10; req_addr = 12'hC00; req_wdata = 32'h0;
    @(negedge clk);
    chk("t5_accept", req_ready, 1);
    @(posedge clk); #1;
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    req_valid = 0;
    tick();
    @(negedge clk);
    chk("t5_lo_valid", rsp_valid, 1);
    chk("t5_lo", rsp_rdata, 32'hFFFF_FFFF);
    tick();
    do_req(2'b10, 12'hC80, 32'h0, rd, e, lat);
`ifdef CSR_HI_SNAPSHOT_EN
    chk("t5_hi_snapshot", rd, 32'h0);
`else
    chk("t5_hi_live", rd, 32'h1);
`endif

    // 6: reset while a request is in ACCESS drops it silently
    do_req(2'b01, 12'h340, 32'h55, rd, e, lat);
    req_valid = 1; req_op = 2'b01; req_addr = 12'h340; req_wdata = 32'h1234;
    @(negedge clk);
    chk("t6_accept", req_ready, 1);
    tick();
    req_valid = 0;
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_rsp_rst", rsp_valid, 0);
      tick();
    end
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_rsp_after", rsp_valid, 0);
      tick();
    end
    do_req(2'b10, 12'h340, 32'h0, rd, e, lat);
    chk("t6_mscratch_rst", rd, 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      req_valid  = ($urandom_range(0, 9) < 6);
      req_op     = 2'($urandom);
      req_addr   = addrs[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0:       req_wdata = 32'h0;
        1:       req_wdata = 32'($urandom) & 32'h0000_0088;
        default: req_wdata = 32'($urandom);
      endcase
      trap_valid = ($urandom_range(0, 19) == 0);
      trap_pc    = 32'($urandom);
      trap_cause = 32'($urandom);
      mret_valid = ($urandom_range(0, 14) == 0);
      retire     = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 0; req_valid = 0; trap_valid = 0; mret_valid = 0; retire = 0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
